// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// LSU_MISALIGN_TRAP_EN selects trap vs. mask handling of misaligned accesses.
package lsu_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_READ,
    WRITE,
    RESP
  } lsu_state_e;

  // True when the low address bits break natural alignment.
  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] lo
  );
    return (size == SIZE_HALF && lo[0]) ||
           (size[1] && lo != 2'b00);
  endfunction

  // Low address bits forced to the natural alignment of size.
  function automatic logic [1:0] align_low(
    input logic [1:0] size,
    input logic [1:0] lo
  );
    if (size == SIZE_BYTE) return lo;
    if (size == SIZE_HALF) return {lo[1], 1'b0};
    return 2'b00;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Pipeline-side request/response bundle of the load/store unit.
// master = pipeline, slave = load_store_unit.
interface lsu_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          reqValid;
  logic          reqReady;
  logic          reqWrite;
  logic [1:0]    reqSize;
  logic          reqSigned;
  logic [AW-1:0] reqAddress;
  logic [DW-1:0] reqWData;
  logic          respValid;
  logic [DW-1:0] respRData;
  logic          respError;

  modport master (
    output reqValid, reqWrite, reqSize,
    output reqSigned, reqAddress, reqWData,
    input  reqReady, respValid,
    input  respRData, respError
  );

  modport slave (
    input  reqValid, reqWrite, reqSize,
    input  reqSigned, reqAddress, reqWData,
    output reqReady, respValid,
    output respRData, respError
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane merge for sub-word stores and
// extract/extend for loads (32-bit words only).
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] word_i,
  input  logic [DATA_WIDTH-1:0] store_data_i,
  input  logic [1:0]            addr_low_i,
  input  logic [1:0]            size_i,
  input  logic                  signed_i,
  output logic [DATA_WIDTH-1:0] merged_o,
  output logic [DATA_WIDTH-1:0] load_data_o
);

  logic [4:0]  sh_b;
  logic [4:0]  sh_h;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign sh_b = {addr_low_i, 3'b000};
  assign sh_h = {addr_low_i[1], 4'b0000};

  // Store side: overwrite only the addressed lane(s).
  always_comb begin
    merged_o = word_i;
    unique case (size_i)
      SIZE_BYTE: merged_o[sh_b +: 8]  = store_data_i[7:0];
      SIZE_HALF: merged_o[sh_h +: 16] = store_data_i[15:0];
      default:   merged_o = store_data_i;
    endcase
  end

  // Load side: shift lane down, then sign/zero extend.
  always_comb begin
    lane_b      = word_i[sh_b +: 8];
    lane_h      = word_i[sh_h +: 16];
    load_data_o = word_i;
    unique case (size_i)
      SIZE_BYTE:
        load_data_o = {{24{signed_i & lane_b[7]}}, lane_b};
      SIZE_HALF:
        load_data_o = {{16{signed_i & lane_h[15]}}, lane_h};
      default:
        load_data_o = word_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage initiator for the word-wide data memory.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  lsu_if.slave                  bus,
  output logic [ADDR_WIDTH-1:0] memAddress,
  output logic                  memWriteEnable,
  output logic [DATA_WIDTH-1:0] memDataWrite,
  input  logic [DATA_WIDTH-1:0] memDataOutput
);

  lsu_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            size_q, size_d;
  logic                  signed_q, signed_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] mdw_q, mdw_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
  logic                  err_q, err_d;
`endif

  logic [1:0]            size_in;
  logic                  trap;
  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] ld_data;

  lsu_lane_align u_align (
    .word_i      (memDataOutput),
    .store_data_i(wdata_q),
    .addr_low_i  (addr_q[1:0]),
    .size_i      (size_q),
    .signed_i    (signed_q),
    .merged_o    (merged),
    .load_data_o (ld_data)
  );

  // Request capture and sequencing of the memory access.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    size_d   = size_q;
    signed_d = signed_q;
    wdata_d  = wdata_q;
    mdw_d    = mdw_q;
    rdata_d  = rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
    err_d    = err_q;
`endif
    size_in  = (bus.reqSize == 2'd3) ? SIZE_WORD
                                     : bus.reqSize;
    trap     = 1'b0;
    unique case (state_q)
      IDLE: if (bus.reqValid) begin
        addr_d   = bus.reqAddress;
        size_d   = size_in;
        signed_d = bus.reqSigned;
        wdata_d  = bus.reqWData;
`ifdef LSU_MISALIGN_TRAP_EN
        trap  = misaligned(size_in, bus.reqAddress[1:0]);
        err_d = trap;
`else
        addr_d[1:0] = align_low(size_in, bus.reqAddress[1:0]);
`endif
        if (trap) begin
          state_d = RESP;
          rdata_d = '0;
        end else if (!bus.reqWrite) begin
          state_d = LOAD;
        end else if (size_in == SIZE_WORD) begin
          state_d = WRITE;
          mdw_d   = bus.reqWData;
        end else begin
          state_d = RMW_READ;
        end
      end
      LOAD: begin
        rdata_d = ld_data;
        state_d = RESP;
      end
      RMW_READ: begin
        mdw_d   = merged;
        state_d = WRITE;
      end
      WRITE: begin
        rdata_d = '0;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset drops any in-flight request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      size_q   <= SIZE_BYTE;
      signed_q <= 1'b0;
      wdata_q  <= '0;
      mdw_q    <= '0;
      rdata_q  <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      wdata_q  <= wdata_d;
      mdw_q    <= mdw_d;
      rdata_q  <= rdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
      err_q    <= err_d;
`endif
    end
  end

  assign bus.reqReady  = (state_q == IDLE);
  assign bus.respValid = (state_q == RESP);
  assign bus.respRData = rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
  assign bus.respError = (state_q == RESP) && err_q;
`else
  assign bus.respError = 1'b0;
`endif

  assign memAddress     = {2'b00, addr_q[ADDR_WIDTH-1:2]};
  assign memWriteEnable = (state_q == WRITE) && !rst;
  assign memDataWrite   = mdw_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a byte-level memory model.
// Honours LSU_MISALIGN_TRAP_EN the same way as the design.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_if #(.AW(32), .DW(32)) bus ();

  logic [31:0] memAddress;
  logic        memWriteEnable;
  logic [31:0] memDataWrite;
  logic [31:0] memDataOutput;

  load_store_unit #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .memAddress    (memAddress),
    .memWriteEnable(memWriteEnable),
    .memDataWrite  (memDataWrite),
    .memDataOutput (memDataOutput)
  );

  logic [31:0] mem  [64];
  logic [31:0] rmem [64];
  logic        pl_en  = 1'b0;
  logic [5:0]  pl_idx = '0;
  logic [31:0] pl_val = '0;

  assign memDataOutput = mem[memAddress[5:0]];

  always @(posedge clk) begin
    if (memWriteEnable) mem[memAddress[5:0]] <= memDataWrite;
    if (pl_en) mem[pl_idx] <= pl_val;
  end

  int cyc = 0;
  int wr_total = 0;
  int rst_wr_viol = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (memWriteEnable) wr_total <= wr_total + 1;
  end
  always @(negedge clk)
    if (rst && memWriteEnable) rst_wr_viol <= rst_wr_viol + 1;

  typedef struct {
    int          acc;
    int          lat;
    logic [31:0] rdata;
    logic        err;
    bit          st;
    int          idx;
    logic [31:0] word;
    int          writes;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int wr_seen = 0;
  int n_resp = 0;
  int n_issued = 0;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference: byte-granular memory semantics.
  function automatic exp_t model(input bit wr,
                                 input logic [1:0] sz,
                                 input bit sg,
                                 input logic [31:0] a,
                                 input logic [31:0] d);
    exp_t e;
    int nb, off;
    logic [31:0] w, v;
    bit mis;
    nb = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    mis = (a % nb) != 0;
    e.rdata = '0; e.err = 1'b0; e.st = 1'b0;
    e.writes = 0; e.word = '0;
    e.idx = int'(a / 4) % 64;
    e.lat = 2;
    e.acc = 0;
`ifdef LSU_MISALIGN_TRAP_EN
    if (mis) begin
      e.err = 1'b1;
      e.lat = 1;
      return e;
    end
`else
    if (mis) e.lat = 2;
`endif
    off = (int'(a % 4) / nb) * nb;
    w = rmem[e.idx];
    if (!wr) begin
      v = '0;
      for (int i = 0; i < nb; i++)
        v = v | (((w >> (8 * (off + i))) & 32'hFF) << (8 * i));
      if (sg && nb < 4 && v[8*nb-1])
        v = v | (32'hFFFF_FFFF << (8 * nb));
      e.rdata = v;
    end else begin
      for (int i = 0; i < nb; i++)
        w[8*(off+i) +: 8] = d[8*i +: 8];
      rmem[e.idx] = w;
      e.st = 1'b1;
      e.word = w;
      e.writes = 1;
      e.lat = (nb == 4) ? 2 : 3;
    end
    return e;
  endfunction

  // Monitor: every response is matched against the queue head.
  always @(negedge clk) begin
    if (!rst && bus.respValid) begin
      exp_t e;
      n_resp++;
      last_rdata = bus.respRData;
      last_err = bus.respError;
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL resp_unexpected: got response want none");
      end else begin
        e = q.pop_front();
        chk("latency", 32'(cyc - e.acc), 32'(e.lat));
        chk("rdata", bus.respRData, e.rdata);
        chk("error", {31'b0, bus.respError}, {31'b0, e.err});
        chk("writes", 32'(wr_total - wr_seen), 32'(e.writes));
        if (e.st) chk("memword", mem[e.idx], e.word);
      end
      wr_seen = wr_total;
    end
  end

  task automatic poke(input int idx, input logic [31:0] val);
    pl_en = 1'b1;
    pl_idx = 6'(idx);
    pl_val = val;
    rmem[idx] = val;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Called at posedge+1; returns at posedge+1 after acceptance.
  task automatic issue(input bit wr, input logic [1:0] sz,
                       input bit sg, input logic [31:0] a,
                       input logic [31:0] d, input bit track);
    int n, acc;
    exp_t e;
    bus.reqValid = 1'b1;
    bus.reqWrite = wr;
    bus.reqSize = sz;
    bus.reqSigned = sg;
    bus.reqAddress = a;
    bus.reqWData = d;
    n = 0;
    @(negedge clk);
    while (!bus.reqReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.reqReady) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got ready=0 want 1");
      @(posedge clk); #1;
    end else begin
      acc = cyc;
      @(posedge clk); #1;
      if (track) begin
        e = model(wr, sz, sg, a, d);
        e.acc = acc;
        q.push_back(e);
        n_issued++;
      end
    end
  endtask

  task automatic drain();
    int n;
    bus.reqValid = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending want 0",
               q.size());
      q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    bus.reqValid = 1'b0;
    bus.reqWrite = 1'b0;
    bus.reqSize = 2'd0;
    bus.reqSigned = 1'b0;
    bus.reqAddress = '0;
    bus.reqWData = '0;
    @(posedge clk); #1;
    for (int i = 0; i < 64; i++) poke(i, $urandom);

    @(negedge clk);
    chk("rst_ready", {31'b0, bus.reqReady}, 32'd1);
    chk("rst_respValid", {31'b0, bus.respValid}, 32'd0);
    chk("rst_respError", {31'b0, bus.respError}, 32'd0);
    chk("rst_respRData", bus.respRData, 32'd0);
    chk("rst_memAddress", memAddress, 32'd0);
    chk("rst_memWE", {31'b0, memWriteEnable}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Word store then word load of the same address.
    issue(1, 2'd2, 0, 32'h24, 32'h55, 1);
    bus.reqValid = 1'b0;
    @(negedge clk);
    chk("t2_memAddress", memAddress, 32'd9);
    drain();
    issue(0, 2'd2, 0, 32'h24, 32'h0, 1);
    drain();
    chk("t2_load", last_rdata, 32'h55);

    // Byte store merge.
    poke(10, 32'h1122_3344);
    issue(1, 2'd0, 0, 32'h29, 32'hAB, 1);
    drain();
    chk("t3_mem10", mem[10], 32'h1122_AB44);

    // Sub-word load extraction.
    poke(11, 32'h8000_F0FF);
    issue(0, 2'd0, 1, 32'h2C, 32'h0, 1);
    drain();
    chk("t4_lb", last_rdata, 32'hFFFF_FFFF);
    issue(0, 2'd1, 0, 32'h2E, 32'h0, 1);
    drain();
    chk("t4_lhu", last_rdata, 32'h0000_8000);
    issue(0, 2'd1, 1, 32'h2C, 32'h0, 1);
    drain();
    chk("t4_lh", last_rdata, 32'hFFFF_F0FF);

    // Misaligned word load.
    issue(0, 2'd2, 0, 32'h26, 32'h0, 1);
    drain();
`ifdef LSU_MISALIGN_TRAP_EN
    chk("t6_err", {31'b0, last_err}, 32'd1);
    chk("t6_rdata", last_rdata, 32'd0);
`else
    chk("t6_err", {31'b0, last_err}, 32'd0);
    chk("t6_rdata", last_rdata, 32'h55);
`endif

    // Reset asserted while the write is pending.
    issue(1, 2'd2, 0, 32'h30, 32'hDEAD_BEEF, 0);
    bus.reqValid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_ready", {31'b0, bus.reqReady}, 32'd1);
    chk("t1_respValid", {31'b0, bus.respValid}, 32'd0);
    chk("t1_viol", 32'(rst_wr_viol), 32'd0);
    chk("t1_mem12", mem[12], rmem[12]);
    @(posedge clk); #1;
    rst = 1'b0;
    wr_seen = wr_total;

    // Back-to-back with reqValid held high.
    for (int i = 0; i < 3; i++)
      issue(1'($urandom), 2'($urandom), 1'($urandom),
            32'($urandom_range(0, 255)), $urandom, 1);
    drain();

    // Random traffic with occasional gaps.
    for (int i = 0; i < 150; i++) begin
      issue(1'($urandom), 2'($urandom), 1'($urandom),
            32'($urandom_range(0, 255)), $urandom, 1);
      if ($urandom_range(0, 3) == 0) begin
        bus.reqValid = 1'b0;
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk); #1;
        end
      end
    end
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("resp_count", 32'(n_resp), 32'(n_issued));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
